// File: rtl/stopwatch_ctrl_pkg.sv
// Shared types and constants for the four-digit BCD stopwatch controller.
package stopwatch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_LAP   = 2'd3
    } sw_state_e;

    localparam int unsigned NDIGITS = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage

// File: rtl/stopwatch_ctrl_bcd_digit.sv
// One decade counter of the stopwatch chain; at_max feeds the next digit's enable.
module bcd_digit
    import stopwatch_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       at_max
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        at_max = (q_q == BCD_MAX);
        q_d    = q_q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = at_max ? 4'd0 : q_q + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: tick prescaler, run/pause/lap FSM, digit carry chain,
// lap display latch and wrap pulse.
module stopwatch_ctrl
    import stopwatch_ctrl_pkg::*;
#(
    parameter int unsigned PRESCALE = 100000,
    parameter int unsigned PW       = 17
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        clear,
    output logic [15:0] disp,
    output logic        running,
    output logic        lap_active,
    output logic        ovl
);

    sw_state_e state_q, state_d;
    logic [PW-1:0]          presc_q, presc_d;
    logic [NDIGITS*4-1:0]   count;
    logic [NDIGITS*4-1:0]   latch_q, latch_d;
    logic                   ovl_q, ovl_d;
    logic [NDIGITS-1:0]     dig_en;
    logic [NDIGITS-1:0]     dig_max;
    logic                   active;
    logic                   tick;
    logic                   capture;
    logic                   clr_cnt;

    assign active = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick   = active && (presc_q == PW'(PRESCALE - 1));

    // Only one event is acted on per cycle; the else-if chain gives start_stop > lap > clear.
    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        clr_cnt = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_stop) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = ST_LAP;
                    capture = 1'b1;
                end
            end
            ST_LAP: begin
                if (start_stop) begin
                    state_d = ST_PAUSE;
                end else if (lap) begin
                    state_d = ST_RUN;
                end
            end
            ST_PAUSE: begin
                if (start_stop) begin
                    state_d = ST_RUN;
                end else if (clear) begin
                    state_d = ST_IDLE;
                    clr_cnt = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Prescaler holds in PAUSE so a resume finishes the interrupted period.
    always_comb begin
        presc_d = presc_q;
        if (clr_cnt || state_q == ST_IDLE) begin
            presc_d = '0;
        end else if (active) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        dig_en[0] = tick;
        for (int unsigned i = 1; i < NDIGITS; i++) begin
            dig_en[i] = dig_en[i-1] && dig_max[i-1];
        end
    end

    genvar g;
    generate
        for (g = 0; g < NDIGITS; g++) begin : g_digit
            bcd_digit u_digit (
                .clk    (clk),
                .rst_n  (rst_n),
                .en     (dig_en[g]),
                .clr    (clr_cnt),
                .q      (count[g*4 +: 4]),
                .at_max (dig_max[g])
            );
        end
    endgenerate

    assign ovl_d   = tick && (&dig_max);
    assign latch_d = capture ? count : latch_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            latch_q <= '0;
            ovl_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            latch_q <= latch_d;
            ovl_q   <= ovl_d;
        end
    end

    assign disp       = (state_q == ST_LAP) ? latch_q : count;
    assign running    = active;
    assign lap_active = (state_q == ST_LAP);
    assign ovl        = ovl_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed and random stimulus for stopwatch_ctrl against an arithmetic reference model.
module tb_stopwatch_ctrl;

    localparam int unsigned PRESCALE = 4;
    localparam int unsigned PW       = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap = 1'b0;
    logic        clear = 1'b0;
    logic [15:0] disp;
    logic        running;
    logic        lap_active;
    logic        ovl;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: count kept as a plain integer 0..9999.
    int m_count, m_presc, m_latch;
    bit m_run, m_pause, m_lap, m_ovl;

    stopwatch_ctrl #(.PRESCALE(PRESCALE), .PW(PW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start_stop (start_stop),
        .lap        (lap),
        .clear      (clear),
        .disp       (disp),
        .running    (running),
        .lap_active (lap_active),
        .ovl        (ovl)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] to_bcd(int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_count = 0; m_presc = 0; m_latch = 0;
        m_run = 0; m_pause = 0; m_lap = 0; m_ovl = 0;
    endtask

    task automatic check_all();
        check("disp", 32'(disp), 32'(m_lap ? to_bcd(m_latch) : to_bcd(m_count)));
        check("running", 32'(running), 32'(m_run || m_lap));
        check("lap_active", 32'(lap_active), 32'(m_lap));
        check("ovl", 32'(ovl), 32'(m_ovl));
    endtask

    task automatic model_edge(bit ss, bit lp, bit cl);
        bit act, tick, idle;
        int old;
        act  = m_run || m_lap;
        idle = !m_run && !m_pause && !m_lap;
        tick = act && (m_presc == PRESCALE - 1);
        old  = m_count;
        m_ovl = tick && (old == 9999);
        if (tick) m_count = (old + 1) % 10000;
        if (idle) m_presc = 0;
        else if (act) m_presc = tick ? 0 : m_presc + 1;
        if (ss) begin
            if (idle)        m_run = 1;
            else if (m_run)  begin m_run = 0; m_pause = 1; end
            else if (m_lap)  begin m_lap = 0; m_pause = 1; end
            else             begin m_pause = 0; m_run = 1; end
        end else if (lp) begin
            if (m_run)       begin m_run = 0; m_lap = 1; m_latch = old; end
            else if (m_lap)  begin m_lap = 0; m_run = 1; end
        end else if (cl && m_pause) begin
            m_pause = 0; m_count = 0; m_presc = 0;
        end
    endtask

    task automatic step(bit ss, bit lp, bit cl);
        start_stop = ss; lap = lp; clear = cl;
        @(posedge clk);
        model_edge(ss, lp, cl);
        #1;
        start_stop = 1'b0; lap = 1'b0; clear = 1'b0;
        check_all();
    endtask

    task automatic run_to(int target, int limit, string tag);
        int n = 0;
        while (m_count != target && n < limit) begin
            step(1'b0, 1'b0, 1'b0);
            n++;
        end
        check(tag, 32'(disp), 32'(to_bcd(target)));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] held;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_disp", 32'(disp), 32'h0);
        check_all();
        rst_n = 1'b1;

        // Basic count: 40 cycles after start is ten ticks.
        step(1'b1, 1'b0, 1'b0);
        repeat (40) step(1'b0, 1'b0, 1'b0);
        check("count40", 32'(disp), 32'h0010);
        check("count40_run", 32'(running), 32'h1);

        // Carry across two digits lands in one edge; per-cycle checks catch glitches.
        run_to(99, 2000, "reach_0099");
        run_to(100, PRESCALE + 1, "carry_0100");

        // Pause two cycles into the period, resume, increment two cycles later.
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        held = disp;
        repeat (100) step(1'b0, 1'b0, 1'b0);
        check("pause_hold", 32'(disp), 32'(held));
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        check("resume_1", 32'(disp), 32'h0100);
        step(1'b0, 1'b0, 1'b0);
        check("resume_2", 32'(disp), 32'h0101);

        // Clear while paused returns to idle with zero count.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        check("clear_disp", 32'(disp), 32'h0);
        check("clear_run", 32'(running), 32'h0);

        // Lap freezes the display, second lap returns to the live count.
        step(1'b1, 1'b0, 1'b0);
        run_to(5, 100, "reach_0005");
        step(1'b0, 1'b1, 1'b0);
        repeat (20) step(1'b0, 1'b0, 1'b0);
        check("lap_frozen", 32'(disp), 32'h0005);
        check("lap_flag", 32'(lap_active), 32'h1);
        step(1'b0, 1'b1, 1'b0);
        check("lap_live", 32'(disp), 32'h0010);
        check("lap_off", 32'(lap_active), 32'h0);

        // start_stop beats clear in PAUSE; clear is ignored in RUN.
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("ss_clr_run", 32'(running), 32'h1);
        check("ss_clr_keep", 32'(disp), 32'h0010);
        step(1'b0, 1'b0, 1'b1);
        check("clr_in_run", 32'(running), 32'h1);

        // Wrap from 9999 pulses ovl once and keeps counting.
        run_to(9999, 50000, "reach_9999");
        run_to(0, PRESCALE + 1, "wrap_0000");
        check("wrap_ovl", 32'(ovl), 32'h1);
        check("wrap_run", 32'(running), 32'h1);
        step(1'b0, 1'b0, 1'b0);
        check("wrap_ovl_off", 32'(ovl), 32'h0);
        run_to(1, PRESCALE + 1, "wrap_0001");

        // Asynchronous reset mid-run clears outputs before the next edge.
        run_to(3, 100, "reach_0003");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("arst_disp", 32'(disp), 32'h0);
        check("arst_run", 32'(running), 32'h0);
        check_all();
        #1 rst_n = 1'b1;

        // Random single-pulse traffic, plus start_stop combined with other pulses.
        for (int i = 0; i < 4000; i++) begin
            int r;
            r = int'($urandom_range(0, 29));
            case (r)
                0: step(1'b1, 1'b0, 1'b0);
                1: step(1'b0, 1'b1, 1'b0);
                2: step(1'b0, 1'b0, 1'b1);
                3: step(1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                default: step(1'b0, 1'b0, 1'b0);
            endcase
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
